// File: rtl/subtractor_pkg.sv
// subtractor_pkg: shared FSM encoding and sizing helpers for the subtractor
// down-counter and its tick_prescaler sub-module.
package subtractor_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts enabled cycles and raises tick on every PRESCALE-th
// one. clr restarts the count from zero and takes precedence over en.
module tick_prescaler
    import subtractor_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic aclk,
    input  logic arstn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned     CW   = cnt_width(PRESCALE);
    localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: restart on clr, wrap to zero on the qualifying cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Prescale count register.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/subtractor.sv
// subtractor: loadable down-counter with prescaled decrement and a single-cycle
// done pulse on reaching zero. Priority each cycle is clr > load > dec.
// Optional build macro SUBTRACTOR_RELOAD_EN turns it into a periodic timer by
// reloading the last accepted load value when the count expires.
module subtractor
    import subtractor_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             busy_q;
    logic             done_q;
    logic             tick;
    logic             pre_clr;
    logic             pre_en;

`ifdef SUBTRACTOR_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
`endif

    // The prescaler only advances on dec cycles that the FSM would honour;
    // any clr or load restarts it so a reloaded count starts a fresh period.
    assign pre_clr = clr || load;
    assign pre_en  = dec && !clr && !load && (state_q == COUNT);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .aclk  (aclk),
        .arstn (arstn),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    // Next-state and next-count selection in clr > load > tick priority.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
`ifdef SUBTRACTOR_RELOAD_EN
        reload_d = reload_q;
`endif
        if (clr) begin
            state_d = IDLE;
            out_d   = '0;
`ifdef SUBTRACTOR_RELOAD_EN
            reload_d = '0;
`endif
        end else if (load) begin
            out_d   = load_val;
            state_d = (load_val != '0) ? COUNT : DONE;
`ifdef SUBTRACTOR_RELOAD_EN
            reload_d = load_val;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                COUNT: begin
                    if (tick) begin
                        out_d = out_q - WIDTH'(1);
                        if (out_q == WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
`ifdef SUBTRACTOR_RELOAD_EN
                    if (reload_q != '0) begin
                        out_d   = reload_q;
                        state_d = COUNT;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                    out_d   = '0;
                end
            endcase
        end
    end

    // State, count and flag registers; busy/done are registered decodes of
    // the next state so they line up with the state they describe.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= (state_d == COUNT);
            done_q  <= (state_d == DONE);
        end
    end

`ifdef SUBTRACTOR_RELOAD_EN
    // Reload value register, captured on every accepted load.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
